// File: rtl/seq_alu.sv
// Multi-cycle EXE-stage ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned shift-add multiply and restoring divide, with a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_ITER | WIDTH iterations of multiply or divide, one bit per cycle
// S_DONE | done pulse; result registers were loaded on entry
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0100;
  localparam logic [3:0] CMD_OR   = 4'b0101;
  localparam logic [3:0] CMD_NOR  = 4'b0110;
  localparam logic [3:0] CMD_XOR  = 4'b0111;
  localparam logic [3:0] CMD_SLL  = 4'b1000;
  localparam logic [3:0] CMD_SRA  = 4'b1001;
  localparam logic [3:0] CMD_SRL  = 4'b1010;
  localparam logic [3:0] CMD_MULU = 4'b1011;
  localparam logic [3:0] CMD_DIVU = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t             state;
  logic [3:0]         cmd_q;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   reg_a;   // mul: upper accumulator, div: partial remainder
  logic [WIDTH-1:0]   reg_b;   // mul: multiplier/low product, div: dividend/quotient
  logic [WIDTH-1:0]   reg_c;   // mul: multiplicand, div: divisor

  logic [WIDTH-1:0]   quick_lo, quick_hi;
  logic               quick_dbz;
  logic               needs_iter;
  logic [SHAMT_W-1:0] shamt;

  assign busy  = (state != S_IDLE);
  assign shamt = val2[SHAMT_W-1:0];
  assign needs_iter = ((exe_cmd == CMD_MULU) || (exe_cmd == CMD_DIVU)) && (val2 != '0);

  always_comb begin
    quick_lo  = '0;
    quick_hi  = '0;
    quick_dbz = 1'b0;
    case (exe_cmd)
      CMD_ADD: quick_lo = val1 + val2;
      CMD_SUB: quick_lo = val1 - val2;
      CMD_AND: quick_lo = val1 & val2;
      CMD_OR:  quick_lo = val1 | val2;
      CMD_NOR: quick_lo = ~(val1 | val2);
      CMD_XOR: quick_lo = val1 ^ val2;
      CMD_SLL: quick_lo = val1 << shamt;
      CMD_SRA: quick_lo = $signed(val1) >>> shamt;
      CMD_SRL: quick_lo = val1 >> shamt;
      CMD_DIVU: begin
        if (val2 == '0) begin
          quick_lo  = '1;
          quick_hi  = val1;
          quick_dbz = 1'b1;
        end
      end
      default: quick_lo = '0;
    endcase
  end

  // One iteration step of each algorithm; the next-state values are also
  // what lands in result/result_hi on the final iteration.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_a, nxt_b;

  always_comb begin
    mul_sum   = {1'b0, reg_a} + (reg_b[0] ? {1'b0, reg_c} : '0);
    div_shift = {reg_a, reg_b[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, reg_c};
    div_ge    = ~div_diff[WIDTH+1];
    if (cmd_q == CMD_MULU) begin
      nxt_a = mul_sum[WIDTH:1];
      nxt_b = {mul_sum[0], reg_b[WIDTH-1:1]};
    end else begin
      nxt_a = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      nxt_b = {reg_b[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      cnt         <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      reg_c       <= '0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_q       <= exe_cmd;
            div_by_zero <= 1'b0;
            if (needs_iter) begin
              state <= S_ITER;
              cnt   <= '0;
              reg_a <= '0;
              reg_b <= (exe_cmd == CMD_MULU) ? val2 : val1;
              reg_c <= (exe_cmd == CMD_MULU) ? val1 : val2;
            end else begin
              state       <= S_DONE;
              done        <= 1'b1;
              result      <= quick_lo;
              result_hi   <= quick_hi;
              div_by_zero <= quick_dbz;
            end
          end
        end
        S_ITER: begin
          reg_a <= nxt_a;
          reg_b <= nxt_b;
          cnt   <= cnt + 1'b1;
          if (cnt == SHAMT_W'(WIDTH - 1)) begin
            state     <= S_DONE;
            cnt       <= '0;
            done      <= 1'b1;
            result    <= nxt_b;
            result_hi <= nxt_a;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: latency/result model from plain arithmetic checked every
// cycle, plus directed vectors with literal expectations.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   exe_cmd = '0;
  logic [W-1:0] val1 = '0, val2 = '0;
  logic         busy, done, dbz;
  logic [W-1:0] result, result_hi;

  seq_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .exe_cmd(exe_cmd),
    .val1(val1), .val2(val2), .busy(busy), .done(done),
    .result(result), .result_hi(result_hi), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Golden behaviour straight from the operation definitions.
  function automatic void golden(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [W-1:0] h,
                                 output logic dz, output int lat);
    logic [2*W-1:0] p;
    int sh;
    sh  = int'(b % W);
    r   = '0; h = '0; dz = 1'b0; lat = 1;
    case (c)
      4'h0: r = a + b;
      4'h2: r = a - b;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = ~(a | b);
      4'h7: r = a ^ b;
      4'h8: r = a << sh;
      4'h9: r = W'($signed(a) >>> sh);
      4'hA: r = a >> sh;
      4'hB: begin
        p = 64'(a) * 64'(b);
        r = p[W-1:0];
        h = p[2*W-1:W];
        lat = (b != 0) ? W + 1 : 1;
      end
      4'hC: begin
        if (b == 0) begin
          r = '1; h = a; dz = 1'b1;
        end else begin
          r = a / b; h = a % b; lat = W + 1;
        end
      end
      default: ;
    endcase
  endfunction

  // Model: m_cnt = cycles left in flight; done is the cycle with one left.
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0, m_hi = '0, p_res, p_hi;
  logic         m_dbz = 1'b0, p_dbz;
  int           p_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_res = '0; m_hi = '0; m_dbz = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        golden(exe_cmd, val1, val2, p_res, p_hi, p_dbz, p_lat);
        m_cnt = p_lat;
        m_dbz = 1'b0;
        if (m_cnt == 1) begin m_res = p_res; m_hi = p_hi; m_dbz = p_dbz; end
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin m_res = p_res; m_hi = p_hi; m_dbz = p_dbz; end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", busy, m_cnt > 0);
      chk("m_done", done, m_cnt == 1);
      chk("m_result", result, m_res);
      chk("m_result_hi", result_hi, m_hi);
      chk("m_dbz", dbz, m_dbz);
    end
  end

  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int t_acc);
    @(negedge clk);
    start = 1'b1; exe_cmd = c; val1 = a; val2 = b;
    @(negedge clk);
    t_acc = cyc;
    start = 1'b0; exe_cmd = 4'($urandom); val1 = $urandom; val2 = $urandom;
  endtask

  task automatic wait_done(input int t_acc, output int lat);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
    lat = cyc - t_acc + 1;
  endtask

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a, b, r, h;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, lat;
    vt[0]  = '{4'h0, 32'd1546,      32'd1,         32'd1547,      32'd0, 1'b0, 1};
    vt[1]  = '{4'h2, 32'd5,         32'd7,         32'hFFFFFFFE,  32'd0, 1'b0, 1};
    vt[2]  = '{4'h4, 32'hF0F000FF,  32'h0FF00F0F,  32'h00F0000F,  32'd0, 1'b0, 1};
    vt[3]  = '{4'h5, 32'hF0F000FF,  32'h0FF00F0F,  32'hFFF00FFF,  32'd0, 1'b0, 1};
    vt[4]  = '{4'h6, 32'hF0F000FF,  32'h0FF00F0F,  32'h000FF000,  32'd0, 1'b0, 1};
    vt[5]  = '{4'h7, 32'hF0F000FF,  32'h0FF00F0F,  32'hFF000FF0,  32'd0, 1'b0, 1};
    vt[6]  = '{4'h8, 32'd1,         32'h00000021,  32'd2,         32'd0, 1'b0, 1};
    vt[7]  = '{4'h9, 32'hFFFFF9F6,  32'h00000022,  32'hFFFFFE7D,  32'd0, 1'b0, 1};
    vt[8]  = '{4'hA, 32'hFFFFF9F6,  32'h00000022,  32'h3FFFFE7D,  32'd0, 1'b0, 1};
    vt[9]  = '{4'h1, 32'd5,         32'd6,         32'd0,         32'd0, 1'b0, 1};
    vt[10] = '{4'hF, 32'd5,         32'd6,         32'd0,         32'd0, 1'b0, 1};
    vt[11] = '{4'hB, 32'd1000,      32'd3000,      32'd3000000,   32'd0, 1'b0, 33};
    vt[12] = '{4'hB, 32'h12345678,  32'd0,         32'd0,         32'd0, 1'b0, 1};
    vt[13] = '{4'hC, 32'hFFFFFFFF,  32'h00000010,  32'h0FFFFFFF,  32'hF, 1'b0, 33};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_dbz", dbz, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(vt[i].c, vt[i].a, vt[i].b, t);
      wait_done(t, lat);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_result", i), result, vt[i].r);
      chk($sformatf("vec%0d_result_hi", i), result_hi, vt[i].h);
      chk($sformatf("vec%0d_dbz", i), dbz, vt[i].dz);
    end

    // Full-scale multiply with a start issued while busy.
    issue(4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, t);
    repeat (3) @(negedge clk);
    start = 1'b1; exe_cmd = 4'h0; val1 = 32'd5; val2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    wait_done(t, lat);
    chk("mulmax_lat", lat, 33);
    chk("mulmax_lo", result, 32'h00000001);
    chk("mulmax_hi", result_hi, 32'hFFFFFFFE);
    repeat (3) begin
      @(negedge clk);
      chk("mulmax_no_second_done", done, 1'b0);
      chk("mulmax_idle", busy, 1'b0);
    end

    // Divide, then a start in the cycle right after done.
    issue(4'hC, 32'd1546, 32'd3, t);
    wait_done(t, lat);
    chk("div_lat", lat, 33);
    chk("div_quot", result, 32'd515);
    chk("div_rem", result_hi, 32'd1);
    chk("div_dbz", dbz, 1'b0);
    issue(4'h4, 32'h0000F0F0, 32'h00000FF0, t);
    wait_done(t, lat);
    chk("b2b_lat", lat, 1);
    chk("b2b_result", result, 32'h000000F0);

    // Divide by zero, then an ADD clears the flag.
    issue(4'hC, 32'd1546, 32'd0, t);
    wait_done(t, lat);
    chk("dz_lat", lat, 1);
    chk("dz_result", result, 32'hFFFFFFFF);
    chk("dz_result_hi", result_hi, 32'd1546);
    chk("dz_flag", dbz, 1'b1);
    issue(4'h0, 32'd3, 32'd4, t);
    chk("dz_cleared", dbz, 1'b0);
    chk("dz_next_add", result, 32'd7);

    // Asynchronous reset in the middle of a multiply.
    issue(4'hB, 32'h00001234, 32'h00005678, t);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_result", result, 0);
    chk("arst_result_hi", result_hi, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(4'h0, 32'd2, 32'd2, t);
    wait_done(t, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_result", result, 32'd4);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle successor to the single-cycle EXE-stage ALU, with a start/busy/done handshake.
- Keeps the existing 4-bit EXE_CMD encoding for the logic, arithmetic and shift ops.
- Adds an iterative unsigned multiplier and divider.
- Sits in the EXE stage; the hazard unit uses busy to stall the pipeline.

Parameters:
WIDTH, 32, datapath width in bits (>= 4).
SHAMT_W, 5, shift-amount bits, equal to log2(WIDTH).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; forces idle
start  input  1  request; accepted only when busy==0
exe_cmd  input  4  operation, sampled at accept
val1  input  WIDTH  operand 1, sampled at accept
val2  input  WIDTH  operand 2 / shift amount, sampled at accept
busy  output  1  high while an operation is in flight (state != IDLE)
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  main result; quotient for DIVU; product low half for MULU
result_hi  output  WIDTH  product high half for MULU; remainder for DIVU; 0 for other ops
div_by_zero  output  1  set with done for DIVU when val2==0; cleared on the next accept

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, result_hi=0, div_by_zero=0, iteration counter=0.
- Reset mid-operation aborts the operation. No done pulse is produced and the operands are discarded.
- States:
  - IDLE: on start, latch operands and exe_cmd. MULU/DIVU with val2!=0 -> ITER. All other cases -> DONE.
  - ITER: runs exactly WIDTH cycles, one bit per cycle; counter 0..WIDTH-1, then -> DONE.
  - DONE: done=1 for exactly this one cycle, then -> IDLE unconditionally.
- busy = (state != IDLE). A start while busy is ignored and never queued.
- A start is accepted in the cycle after done.
- result, result_hi and div_by_zero are written on entry to DONE. They hold until the next DONE.
- Latency, counted from the accept edge:
  - Single-cycle ops: done is high in the cycle after accept (1 cycle).
  - MULU/DIVU: done is high after WIDTH+1 edges (33 for WIDTH=32).
- exe_cmd encoding:
  - 0000 ADD: v1+v2, modulo 2^WIDTH.
  - 0010 SUB: v1-v2, modulo 2^WIDTH.
  - 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL (also used for SLA): v1 << v2[SHAMT_W-1:0].
  - 1001 SRA: true arithmetic right shift; sign bit v1[WIDTH-1] replicated.
  - 1010 SRL: logical right shift.
  - 1011 MULU: unsigned 2*WIDTH product; {result_hi,result}.
  - 1100 DIVU: unsigned restoring divide; result=quotient, result_hi=remainder.
  - 0001, 0011, 1101-1111: result=0, result_hi=0, 1-cycle latency.
- Shifts use only val2[SHAMT_W-1:0]; upper bits of val2 are ignored.
- MULU algorithm: shift-add. Each ITER cycle: if multiplier LSB is set, add multiplicand into the upper accumulator (with carry-out bit), then shift the accumulator right by 1.
- DIVU algorithm: restoring. Each ITER cycle: shift {rem,quot} left by 1, trial-subtract divisor, set the quotient bit if the remainder is non-negative.
- Divide by zero (DIVU with val2==0): skip ITER and complete in 1 cycle. result = all ones, result_hi = val1, div_by_zero=1.
- Operand inputs may change freely after accept; they do not affect an in-flight operation.

Test Plan:
- Single-cycle ADD: ADD val1=1546, val2=1, pulse start -> next cycle done=1, result=1547, result_hi=0. busy=1 during that cycle only.
- Right shifts: SRA val1=0xFFFFF9F6, val2=0x00000022 (shift 2) -> result=0xFFFFFE7D (-387). Same operands with SRL -> 0x3FFFFE7D (1073741437).
- MULU with ignored start: MULU 0xFFFFFFFF x 0xFFFFFFFF. Issue start again with ADD at cycle 5 (ignored).
  - busy stays high for 33 cycles.
  - done occurs exactly 33 edges after accept.
  - result_hi=0xFFFFFFFE, result=0x00000001.
  - No second done pulse.
- DIVU and back-to-back start: DIVU 1546 / 3 -> after 33 cycles result=515, result_hi=1, div_by_zero=0. A start with AND in the cycle after done is accepted.
- Divide by zero: DIVU 1546 / 0 -> done at 1-cycle latency, result=0xFFFFFFFF, result_hi=1546, div_by_zero=1. The next ADD clears div_by_zero at accept.
- Reset mid-operation: MULU in flight, assert rst asynchronously at ITER cycle 10 (between edges).
  - busy, done, result and result_hi go to 0 immediately.
  - After release, a new ADD 2+2 gives result=4 with 1-cycle latency.
